// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: FSM state encoding,
// opcode/function constants, PC source encodings and the bundle of
// datapath enables driven by the controller.
package ctrl_pkg;

  // FSM state encoding, also exported on the debug state port.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  // Opcode map.
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_BLT   = 4'b0100;
  localparam logic [3:0] OP_BGT   = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // R-type function codes; FN_SUB also writes r0 in WB.
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_MUL = 4'b0010;

  // pcSource encodings.
  localparam logic [1:0] PCSRC_INC    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // All controller outputs except the debug state.
  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       reg_write;
    logic       r0_write;
    logic       ra1_source;
    logic       ra2_source;
    logic       alu_source;
    logic       mem_read;
    logic       mem_write;
    logic       mem_source;
    logic       fn_offset;
    logic       halt;
    logic       fault;
  } ctrl_out_t;

endpackage

// File: rtl/ctrl_timeout.sv
// Saturating memory-wait counter.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clear     - restart the count (asserted on every FSM state change)
//   count_en  - a FETCH/MEM cycle without mem_ready
//   expired   - count has reached LIMIT; held until clear or rst
module ctrl_timeout #(
  parameter int LIMIT = 15,
  parameter int W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [W-1:0] count;

  assign expired = (count == W'(LIMIT));

  // Wait counter: clear has priority, then saturating increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle controller for the 16-bit datapath. Steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, handshakes with memory via mem_ready,
// and parks in HALT or FAULT (both left only through rst).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   opCode, functionCode     - instruction register fields (latched in DECODE)
//   mem_ready                - memory finished this cycle (FETCH/MEM only)
//   branch_taken             - ALU comparison result, used in EXEC
//   irWrite .. fnOffset      - per-phase datapath enables
//   halt, fault              - core stopped / stopped on an error
//   state                    - current FSM state for debug
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OP_W        = 4,
  parameter int FN_W        = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opCode,
  input  logic [FN_W-1:0] functionCode,
  input  logic            mem_ready,
  input  logic            branch_taken,
  output logic            irWrite,
  output logic            pcWrite,
  output logic [1:0]      pcSource,
  output logic            regWrite,
  output logic            r0Write,
  output logic            ra1Source,
  output logic            ra2Source,
  output logic            aluSource,
  output logic            memRead,
  output logic            memWrite,
  output logic            memSource,
  output logic            fnOffset,
  output logic            halt,
  output logic            fault,
  output logic [2:0]      state
);

  localparam logic [OP_W-1:0] K_RTYPE = OP_W'(OP_RTYPE);
  localparam logic [OP_W-1:0] K_BLT   = OP_W'(OP_BLT);
  localparam logic [OP_W-1:0] K_BGT   = OP_W'(OP_BGT);
  localparam logic [OP_W-1:0] K_BEQ   = OP_W'(OP_BEQ);
  localparam logic [OP_W-1:0] K_LOAD  = OP_W'(OP_LOAD);
  localparam logic [OP_W-1:0] K_STORE = OP_W'(OP_STORE);
  localparam logic [OP_W-1:0] K_JMP   = OP_W'(OP_JMP);
  localparam logic [OP_W-1:0] K_HALT  = OP_W'(OP_HALT);
  localparam logic [FN_W-1:0] K_ADD   = FN_W'(FN_ADD);
  localparam logic [FN_W-1:0] K_SUB   = FN_W'(FN_SUB);
  localparam logic [FN_W-1:0] K_MUL   = FN_W'(FN_MUL);

  state_t          cur_state;
  state_t          nxt_state;
  logic [OP_W-1:0] op_lat;
  logic [FN_W-1:0] fn_lat;
  ctrl_out_t       ctl;
  logic            expired;
  logic            wait_cycle;
  logic            leave_state;
  logic            is_load;
  logic            fn_ok;

  assign wait_cycle  = ((cur_state == ST_FETCH) || (cur_state == ST_MEM)) && !mem_ready;
  assign leave_state = (nxt_state != cur_state);
  assign is_load     = (op_lat == K_LOAD);
  assign fn_ok       = (fn_lat == K_ADD) || (fn_lat == K_SUB) || (fn_lat == K_MUL);

  ctrl_timeout #(
    .LIMIT (MEM_TIMEOUT),
    .W     (TO_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (leave_state),
    .count_en (wait_cycle),
    .expired  (expired)
  );

  // State register and op/fn latch (captured during DECODE only).
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_FETCH;
      op_lat    <= '0;
      fn_lat    <= '0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == ST_DECODE) begin
        op_lat <= opCode;
        fn_lat <= functionCode;
      end
    end
  end

  // Next-state decode and per-phase datapath enables.
  always_comb begin
    nxt_state = cur_state;
    ctl       = '0;
    case (cur_state)
      ST_FETCH: begin
        ctl.mem_read = 1'b1;
        // Expiry wins over a late mem_ready in the same cycle.
        if (expired) begin
          nxt_state = ST_FAULT;
        end else if (mem_ready) begin
          ctl.ir_write  = 1'b1;
          ctl.pc_write  = 1'b1;
          ctl.pc_source = PCSRC_INC;
          nxt_state     = ST_DECODE;
        end else begin
          nxt_state = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (opCode)
          K_HALT:  nxt_state = ST_HALT;
          K_RTYPE, K_LOAD, K_STORE, K_BLT, K_BGT, K_BEQ, K_JMP:
                   nxt_state = ST_EXEC;
          default: nxt_state = ST_FAULT;
        endcase
      end
      ST_EXEC: begin
        case (op_lat)
          K_RTYPE: begin
            if (fn_ok) begin
              nxt_state = ST_WB;
            end else begin
              nxt_state = ST_FAULT;
            end
          end
          K_LOAD, K_STORE: begin
            ctl.alu_source = 1'b1;
            ctl.fn_offset  = 1'b1;
            nxt_state      = ST_MEM;
          end
          K_BLT, K_BGT, K_BEQ: begin
            ctl.ra1_source = 1'b1;
            ctl.ra2_source = 1'b1;
            ctl.pc_write   = branch_taken;
            ctl.pc_source  = PCSRC_BRANCH;
            nxt_state      = ST_FETCH;
          end
          K_JMP: begin
            ctl.pc_write  = 1'b1;
            ctl.pc_source = PCSRC_JUMP;
            nxt_state     = ST_FETCH;
          end
          default: nxt_state = ST_FAULT;
        endcase
      end
      ST_MEM: begin
        if (is_load) begin
          ctl.mem_read = 1'b1;
        end else begin
          ctl.mem_write  = 1'b1;
          ctl.mem_source = 1'b1;
        end
        if (expired) begin
          nxt_state = ST_FAULT;
        end else if (mem_ready) begin
          nxt_state = is_load ? ST_WB : ST_FETCH;
        end else begin
          nxt_state = ST_MEM;
        end
      end
      ST_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.r0_write   = (op_lat == K_RTYPE) && (fn_lat == K_SUB);
        ctl.mem_source = is_load;
        nxt_state      = ST_FETCH;
      end
      ST_HALT: begin
        ctl.halt  = 1'b1;
        nxt_state = ST_HALT;
      end
      ST_FAULT: begin
        ctl.halt  = 1'b1;
        ctl.fault = 1'b1;
        nxt_state = ST_FAULT;
      end
      default: nxt_state = ST_FAULT;
    endcase
  end

  // Reset forces every output low, including mid-instruction pcWrite/regWrite.
  assign irWrite   = rst ? 1'b0  : ctl.ir_write;
  assign pcWrite   = rst ? 1'b0  : ctl.pc_write;
  assign pcSource  = rst ? 2'b00 : ctl.pc_source;
  assign regWrite  = rst ? 1'b0  : ctl.reg_write;
  assign r0Write   = rst ? 1'b0  : ctl.r0_write;
  assign ra1Source = rst ? 1'b0  : ctl.ra1_source;
  assign ra2Source = rst ? 1'b0  : ctl.ra2_source;
  assign aluSource = rst ? 1'b0  : ctl.alu_source;
  assign memRead   = rst ? 1'b0  : ctl.mem_read;
  assign memWrite  = rst ? 1'b0  : ctl.mem_write;
  assign memSource = rst ? 1'b0  : ctl.mem_source;
  assign fnOffset  = rst ? 1'b0  : ctl.fn_offset;
  assign halt      = rst ? 1'b0  : ctl.halt;
  assign fault     = rst ? 1'b0  : ctl.fault;
  assign state     = rst ? 3'b000 : cur_state;

endmodule
